sum_multiciclo_param: RTL and testbench

Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, with the carry held in a register between chunks. This trades latency for area relative to a full-width ripple adder. It sits beside the combinational adders as the arithmetic unit for wide datapaths, and uses a start/busy/done handshake.

---
 rtl/sum_multiciclo_param.sv | 138 +++++++++++++
 tb/tb_sum_multiciclo_param.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_multiciclo_param.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock with the carry kept in a register.
// Latency: WIDTH/CHUNK cycles from the accepted start edge to the o_done pulse.
// Backpressure: none; i_start is ignored while o_busy is high (no queueing).
// Optional: define SUM_MULTICICLO_ACCUM_EN to add i_acc (reuse o_suma as operand A).
module sum_multiciclo_param #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sub,
`ifdef SUM_MULTICICLO_ACCUM_EN
    input  logic             i_acc,
`endif
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_suma,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic             capture, last;
    logic [WIDTH-1:0] a_q, b_q, part_q, part_next, a_src;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_sum;

`ifdef SUM_MULTICICLO_ACCUM_EN
    // Accumulate mode feeds the previous result back as operand A.
    assign a_src = i_acc ? o_suma : i_a;
`else
    assign a_src = i_a;
`endif

    assign o_busy = (state_q == S_RUN);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: capture on start in IDLE, leave RUN after the last chunk.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        last    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    capture = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (k_q == K_LAST) begin
                    last    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Chunk adder: select slice k of both operands and merge the sum into the partial result.
    always_comb begin
        a_chunk   = '0;
        b_chunk   = '0;
        part_next = part_q;
        for (int j = 0; j < N; j++) begin
            if (k_q == KW'(j)) begin
                a_chunk = a_q[j*CHUNK +: CHUNK];
                b_chunk = b_q[j*CHUNK +: CHUNK];
            end
        end
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        for (int j = 0; j < N; j++) begin
            if (k_q == KW'(j)) begin
                part_next[j*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            end
        end
    end

    // Datapath: operand capture, per-chunk accumulation and result update on completion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q        <= '0;
            b_q        <= '0;
            part_q     <= '0;
            carry_q    <= 1'b0;
            k_q        <= '0;
            o_done     <= 1'b0;
            o_suma     <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (capture) begin
                // Subtraction is a + ~b + ~borrow, so invert B and the borrow up front.
                a_q     <= a_src;
                b_q     <= i_sub ? ~i_b : i_b;
                carry_q <= i_sub ^ i_carry;
                part_q  <= '0;
                k_q     <= '0;
            end else if (state_q == S_RUN) begin
                part_q  <= part_next;
                carry_q <= chunk_sum[CHUNK];
                k_q     <= k_q + 1'b1;
                if (last) begin
                    o_suma     <= part_next;
                    o_carry    <= chunk_sum[CHUNK];
                    o_overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (part_next[WIDTH-1] != a_q[WIDTH-1]);
                    o_done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sum_multiciclo_param.sv
// Bench for sum_multiciclo_param: three instances (CHUNK 8, 32, 1) share one stimulus stream.
// Expected results come from a plain-arithmetic model and a per-instance acceptance model.
// A monitor pops the scoreboard on each o_done and checks value, latency and busy duration.
module tb_sum_multiciclo_param;

    localparam int W  = 32;
    localparam int ND = 3;
`ifdef SUM_MULTICICLO_ACCUM_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, sub, acc, cin;
    logic [W-1:0]  a, b;
    logic [W-1:0]  suma [ND];
    logic          carry [ND], ovf [ND], busy [ND], done [ND];
    int            cyc = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         v;
        int           cyc;
    } exp_t;

    exp_t          sbq [ND][$];
    int            free_at [ND];
    logic [W-1:0]  last [ND];
    int            busy_cnt [ND];
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sum_multiciclo_param #(.WIDTH(W), .CHUNK(8)) u_c8 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub),
`ifdef SUM_MULTICICLO_ACCUM_EN
        .i_acc(acc),
`endif
        .i_a(a), .i_b(b), .i_carry(cin),
        .o_busy(busy[0]), .o_done(done[0]), .o_suma(suma[0]),
        .o_carry(carry[0]), .o_overflow(ovf[0])
    );

    sum_multiciclo_param #(.WIDTH(W), .CHUNK(32)) u_c32 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub),
`ifdef SUM_MULTICICLO_ACCUM_EN
        .i_acc(acc),
`endif
        .i_a(a), .i_b(b), .i_carry(cin),
        .o_busy(busy[1]), .o_done(done[1]), .o_suma(suma[1]),
        .o_carry(carry[1]), .o_overflow(ovf[1])
    );

    sum_multiciclo_param #(.WIDTH(W), .CHUNK(1)) u_c1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub),
`ifdef SUM_MULTICICLO_ACCUM_EN
        .i_acc(acc),
`endif
        .i_a(a), .i_b(b), .i_carry(cin),
        .o_busy(busy[2]), .o_done(done[2]), .o_suma(suma[2]),
        .o_carry(carry[2]), .o_overflow(ovf[2])
    );

    function automatic int n_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    // Reference: exact integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic ci);
        exp_t    e;
        longint  ua, ub, sa, sb, cl, full, res;
        ua = longint'(aa);
        ub = longint'(bb);
        sa = longint'($signed(aa));
        sb = longint'($signed(bb));
        cl = ci ? 64'sd1 : 64'sd0;
        if (!s) begin
            full = ua + ub + cl;
            res  = sa + sb + cl;
            e.c  = full[32];
        end else begin
            full = ua - ub - cl;
            res  = sa - sb - cl;
            e.c  = (full >= 0);
        end
        e.sum = full[31:0];
        e.v   = (res > 64'sd2147483647) || (res < -64'sd2147483648);
        e.cyc = 0;
        return e;
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, d, act, expv, cyc);
        end
    endtask

    // Called at a negedge; start is sampled at the next posedge and dropped afterwards.
    task automatic issue(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic ci, input logic ac);
        exp_t         e;
        logic [W-1:0] a_eff;
        sub = s; a = aa; b = bb; cin = ci; acc = ac; start = 1'b1;
        for (int d = 0; d < ND; d++) begin
            if (cyc + 1 >= free_at[d]) begin
                a_eff = (ACC_EN && ac) ? last[d] : aa;
                e = model(s, a_eff, bb, ci);
                e.cyc = cyc + 1 + n_of(d);
                free_at[d] = e.cyc + 1;
                last[d] = e.sum;
                sbq[d].push_back(e);
            end
        end
        @(negedge clk);
        start = 1'b0;
        // Operands are don't-care after capture; scramble them.
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom); acc = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            sbq[d].delete();
            free_at[d] = 0;
            last[d] = '0;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_free(input int d);
        for (int t = 0; t < 100 && cyc + 1 < free_at[d]; t++) @(negedge clk);
    endtask

    task automatic wait_all_free();
        for (int d = 0; d < ND; d++) wait_free(d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: reset-state checks and scoreboard comparison on every o_done.
    always @(posedge clk) begin
        exp_t e;
        #1;
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                chk("rst_suma", d, 64'(suma[d]), 64'd0);
                chk("rst_carry", d, 64'(carry[d]), 64'd0);
                chk("rst_ovf", d, 64'(ovf[d]), 64'd0);
                chk("rst_busy", d, 64'(busy[d]), 64'd0);
                chk("rst_done", d, 64'(done[d]), 64'd0);
                busy_cnt[d] = 0;
            end else begin
                if (busy[d]) busy_cnt[d]++;
                if (done[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk("unexpected_done", d, 64'(done[d]), 64'd0);
                    end else begin
                        e = sbq[d].pop_front();
                        chk("suma", d, 64'(suma[d]), 64'(e.sum));
                        chk("carry", d, 64'(carry[d]), 64'(e.c));
                        chk("overflow", d, 64'(ovf[d]), 64'(e.v));
                        chk("latency", d, 64'(cyc), 64'(e.cyc));
                        chk("busy_cycles", d, 64'(busy_cnt[d]), 64'(n_of(d)));
                        chk("busy_at_done", d, 64'(busy[d]), 64'd0);
                    end
                    busy_cnt[d] = 0;
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; acc = 1'b0; cin = 1'b0; a = '0; b = '0;
        for (int d = 0; d < ND; d++) begin
            free_at[d] = 0;
            last[d] = '0;
            busy_cnt[d] = 0;
        end
        idle(3);
        rst = 1'b0;

        // Carry out of full-width add, subtract with and without borrow, signed overflow.
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); wait_all_free();
        issue(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0); wait_all_free();
        issue(1'b1, 32'h0000_0010, 32'h0000_0003, 1'b1, 1'b0); wait_all_free();
        issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); wait_all_free();
        issue(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0); wait_all_free();

        // Start while busy is ignored; start in the o_done cycle is accepted.
        issue(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        idle(1);
        issue(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
        wait_free(0);
        issue(1'b1, 32'hCAFE_0000, 32'h0000_BABE, 1'b1, 1'b0);
        wait_all_free();

        // Reset on the edge that would finish chunk 2 aborts the operation.
        issue(1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0);
        idle(2);
        do_reset();
        issue(1'b0, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0);
        wait_all_free();

        // Random operations with random gaps (the slow instance accepts only some).
        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom), rnd_op(), rnd_op(), 1'($urandom), 1'b0);
            idle($urandom_range(0, 3));
        end
        wait_all_free();

        // Random operations spaced so every instance accepts each one.
        for (int i = 0; i < 20; i++) begin
            issue(1'($urandom), rnd_op(), rnd_op(), 1'($urandom), 1'b0);
            wait_all_free();
        end

`ifdef SUM_MULTICICLO_ACCUM_EN
        // Accumulation starts from 0 after reset: 5, 12, then 0 with carry out.
        do_reset();
        issue(1'b0, $urandom, 32'h0000_0005, 1'b0, 1'b1); wait_all_free();
        issue(1'b0, $urandom, 32'h0000_0007, 1'b0, 1'b1); wait_all_free();
        issue(1'b0, $urandom, 32'hFFFF_FFF4, 1'b0, 1'b1); wait_all_free();
`endif

        idle(3);
        for (int d = 0; d < ND; d++) chk("pending_results", d, 64'(sbq[d].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
